// File: rtl/mult_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mult_controller                                            |
// | Description : Control FSM for a shift-add multiplier. Sequences the      |
// |               datapath through LOAD, WIDTH x (TEST, [ADD], SHIFT), DONE. |
// |               All outputs are Moore outputs decoded from the state.      |
// | Ports       : clk    - clock, rising edge                                |
// |               clr    - synchronous active-high reset                     |
// |               start  - multiply request, sampled in IDLE only            |
// |               b_lsb  - LSB of datapath multiplier register (TEST only)   |
// |               load_a - multiplicand register load enable                 |
// |               load_b - multiplier register load enable                   |
// |               clr_p  - product accumulator clear                         |
// |               load_p - accumulator takes partial sum                     |
// |               shift  - accumulator / multiplier shift right              |
// |               busy   - multiply in progress                              |
// |               done   - one-cycle completion pulse                        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module mult_controller #(
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic clr,
  input  logic start,
  input  logic b_lsb,
  output logic load_a,
  output logic load_b,
  output logic clr_p,
  output logic load_p,
  output logic shift,
  output logic busy,
  output logic done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    TEST  = 3'd2,
    ADD   = 3'd3,
    SHIFT = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] count;

  // State and iteration counter. The counter is cleared in LOAD and advanced
  // in SHIFT; it wraps harmlessly after the final iteration.
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      if (state == LOAD) begin
        count <= '0;
      end else if (state == SHIFT) begin
        count <= count + CW'(1);
      end
    end
  end

  // Next-state and Moore output decode.
  always_comb begin
    state_next = state;
    load_a     = 1'b0;
    load_b     = 1'b0;
    clr_p      = 1'b0;
    load_p     = 1'b0;
    shift      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = LOAD;
      end
      LOAD: begin
        load_a     = 1'b1;
        load_b     = 1'b1;
        clr_p      = 1'b1;
        busy       = 1'b1;
        state_next = TEST;
      end
      TEST: begin
        busy       = 1'b1;
        state_next = b_lsb ? ADD : SHIFT;
      end
      ADD: begin
        load_p     = 1'b1;
        busy       = 1'b1;
        state_next = SHIFT;
      end
      SHIFT: begin
        shift      = 1'b1;
        busy       = 1'b1;
        // Decision uses the pre-increment count.
        state_next = (count == LAST) ? DONE : TEST;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: doc/mult_controller.md
MULT_CONTROLLER -- requirements
Module: mult_controller

Interface
REQ-001 Parameter WIDTH, default 4: operand width, i.e. number of shift-add iterations per multiply; legal range 2..16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 clr  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request a multiply; sampled only in IDLE.
REQ-005 b_lsb  input  1  current LSB of the datapath multiplier register.
REQ-006 load_a  output  1  load enable, multiplicand register.
REQ-007 load_b  output  1  load enable, multiplier register.
REQ-008 clr_p  output  1  clear enable, product accumulator.
REQ-009 load_p  output  1  load enable, accumulator takes the partial sum.
REQ-010 shift  output  1  shift enable, accumulator and multiplier register shift right one bit.
REQ-011 busy  output  1  high while a multiply is in progress.
REQ-012 done  output  1  one-cycle completion pulse.

Function
REQ-013 The FSM SHALL have states IDLE, LOAD, TEST, ADD, SHIFT and DONE, plus an iteration counter of clog2(WIDTH) bits.
REQ-014 All outputs SHALL be Moore outputs decoded from the registered state only, with no combinational path from any input.
REQ-015 In IDLE all outputs SHALL be 0; start=1 at an edge SHALL move the FSM to LOAD.
REQ-016 In LOAD, load_a, load_b, clr_p and busy SHALL be 1; the counter SHALL be cleared to 0; the next state SHALL be TEST.
REQ-017 In TEST, busy SHALL be 1; b_lsb=1 SHALL select ADD next and b_lsb=0 SHALL select SHIFT next.
REQ-018 In ADD, load_p and busy SHALL be 1; the next state SHALL be SHIFT.
REQ-019 In SHIFT, shift and busy SHALL be 1 and the counter SHALL increment.
REQ-020 From SHIFT, the FSM SHALL go to DONE if the pre-increment counter equals WIDTH-1, else to TEST.
REQ-021 In DONE, done SHALL be 1 and busy 0; the next state SHALL be IDLE unconditionally.
REQ-022 Exactly WIDTH shift pulses SHALL occur per multiply, and load_p SHALL pulse once for each multiplier bit equal to 1.
REQ-023 Latency from the start-sampling edge to the done cycle SHALL be 2 + 2*WIDTH + (number of 1 bits in the multiplier) cycles, counting the LOAD cycle as cycle 1.
REQ-024 start in any state other than IDLE SHALL be ignored; a multiply is never aborted or restarted by start.
REQ-025 If start is held high continuously, exactly one IDLE cycle SHALL separate DONE from the next LOAD.
REQ-026 b_lsb SHALL be used only in TEST; its value in other states SHALL have no effect.
REQ-027 At most one of load_p and shift SHALL be 1 in any cycle.

Reset
REQ-028 clr=1 at an edge SHALL force IDLE and counter=0 on that edge, from any state, regardless of start.
REQ-029 While clr=1 and in the cycle after its release, all outputs SHALL be 0.
REQ-030 clr mid-operation SHALL suppress done for the aborted multiply; the next start SHALL perform a full WIDTH-iteration sequence.
REQ-031 clr SHALL take priority over start when both are 1.

Verification
REQ-032 clr=1 for 2 cycles with start=1 -> all outputs 0; after clr drops with start=1 -> LOAD (load_a=load_b=clr_p=1) on the next cycle.
REQ-033 WIDTH=4, b_lsb held 0, one-cycle start -> LOAD, then 4x (TEST, SHIFT), no load_p, done on cycle 10, busy high on cycles 1-9.
REQ-034 WIDTH=4, b_lsb per TEST = 1,0,1,1 (multiplier 1101) -> load_p 3 times, each immediately before shifts 1, 3 and 4; done on cycle 13.
REQ-035 clr pulsed during the ADD of iteration 2 -> IDLE next cycle, no done pulse; a new start then yields 4 shift pulses and done.
REQ-036 start held high, b_lsb=0 -> done, one IDLE cycle, LOAD; busy low for exactly 2 cycles between operations.
REQ-037 WIDTH=8, b_lsb held 1 -> 8 load_p pulses, 8 shift pulses, done on cycle 26.
